// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM control unit for the 8-bit CPU; define MULTICYCLE_CTRL_MEM_WAIT_EN for mem_ready handshake with timeout.
// Opcode[3:0]: 0 add,1 addi,2 sub,3 subi,4 slt,5 slti,6 sra,7 sll,8 nand,9 lw,10 sw,11 beq,12 bne,13 blt,14 jump,15 hlt.
module multicycle_ctrl #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic [1:0]          PCSrc,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error,
  output logic                retire
);
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_HALT
  } state_t;
  localparam logic [3:0] OP_SUB = 4'd2, OP_SUBI = 4'd3, OP_SLT = 4'd4, OP_SLTI = 4'd5,
                         OP_SRA = 4'd6, OP_SLL = 4'd7, OP_NAND = 4'd8, OP_LW = 4'd9,
                         OP_SW = 4'd10, OP_BEQ = 4'd11, OP_BNE = 4'd12, OP_BLT = 4'd13,
                         OP_JMP = 4'd14, OP_HLT = 4'd15;
  if (OPCODE_W < 4 || ALUOP_W < 4 || MEM_TIMEOUT < 1) begin : g_bad_param
    $error("multicycle_ctrl: OPCODE_W/ALUOP_W must be >= 4 and MEM_TIMEOUT >= 1");
  end
  state_t     state, exec_nxt;
  logic [3:0] op, lop, exec_alu;
  logic       zf, lf, bad, rdy, tmo, taken;
  assign op  = Opcode[3:0];
  assign bad = (Opcode >> 4) != '0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          mem_st;
  assign rdy    = mem_ready;
  assign mem_st = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // completion on the last allowed cycle beats the timeout
  assign tmo    = mem_st && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      cnt       <= (mem_st && !mem_ready && !tmo) ? cnt + 1'b1 : '0;
      bus_error <= bus_error | tmo;
    end
`else
  assign rdy       = mem_ready | 1'b1;
  assign tmo       = 1'b0;
  assign bus_error = 1'b0;
`endif
  always_comb begin
    exec_alu = 4'd0;
    case (op)
      OP_SUB, OP_SUBI:         exec_alu = 4'd1;
      OP_SLT, OP_SLTI, OP_BLT: exec_alu = 4'd14;
      OP_SRA:                  exec_alu = 4'd5;
      OP_SLL:                  exec_alu = 4'd4;
      OP_NAND:                 exec_alu = 4'd12;
      OP_BEQ, OP_BNE:          exec_alu = 4'd15;
      default:                 exec_alu = 4'd0;
    endcase
  end
  assign exec_nxt = op == OP_LW ? S_MEM_RD :
                    op == OP_SW ? S_MEM_WR :
                    op == OP_HLT ? S_HALT :
                    (op >= OP_BEQ && op <= OP_JMP) ? S_BRANCH : S_WB;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= S_RESET;
      illegal_op <= 1'b0;
      lop        <= '0;
      zf         <= 1'b0;
      lf         <= 1'b0;
    end else if (tmo) begin
      state <= S_HALT;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (rdy) state <= S_EXEC;
        S_EXEC: begin
          lop        <= op;
          zf         <= alu_zero;
          lf         <= alu_lt;
          illegal_op <= illegal_op | bad;
          state      <= bad ? S_HALT : exec_nxt;
        end
        S_MEM_RD: if (rdy) state <= S_WB;
        S_MEM_WR: if (rdy) state <= S_FETCH;
        S_HALT:   if (resume) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  assign taken    = lop == OP_BEQ ? zf : lop == OP_BNE ? !zf : lf;
  assign ALUOp    = (state == S_EXEC && !bad) ? ALUOP_W'(exec_alu) : '0;
  assign MemRead  = state == S_FETCH || state == S_MEM_RD;
  assign MemWrite = state == S_MEM_WR;
  assign IRWrite  = state == S_FETCH && rdy;
  assign RegWrite = state == S_WB;
  assign MemToReg = state == S_MEM_RD || (state == S_WB && lop == OP_LW);
  assign retire   = state == S_WB || state == S_BRANCH || (state == S_MEM_WR && rdy);
  assign PCWrite  = retire;
  assign PCSrc    = state != S_BRANCH ? 2'd0 : lop == OP_JMP ? 2'd2 : {1'b0, taken};
  assign halted   = state == S_HALT;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle plans expanded into {inputs, expected outputs} vectors, then replayed and compared.
module tb_multicycle_ctrl;
  localparam int OW = 6, AW = 4, TMO = 3;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  typedef struct packed {
    logic [AW-1:0] alu;
    logic          mr, mw, rw, pcw, ir, m2r;
    logic [1:0]    pcs;
    logic          hlt, ill, be, ret;
  } out_t;
  typedef struct {
    logic          rst_n;
    bit            chk;
    logic [OW-1:0] opc;
    logic          z, lt, rdy, res;
    out_t          exp;
    string         tag;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic [OW-1:0] Opcode = '0;
  logic [AW-1:0] ALUOp;
  logic MemRead, MemWrite, RegWrite, PCWrite, IRWrite, MemToReg, halted, illegal_op, bus_error, retire;
  logic [1:0] PCSrc;
  multicycle_ctrl #(.OPCODE_W(OW), .ALUOP_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .mem_ready(mem_ready), .resume(resume), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .PCSrc(PCSrc), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error), .retire(retire)
  );
  always #5 clk = ~clk;
  int   alu_tab [16] = '{0, 0, 1, 1, 14, 14, 5, 4, 12, 0, 0, 15, 15, 14, 0, 0};
  vec_t vq[$];
  bit   ill_s, be_s;
  int   total, bad;
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [OW-1:0] ro();
    return OW'($urandom);
  endfunction
  function automatic out_t base();
    out_t o = '0;
    o.ill = ill_s;
    o.be  = be_s;
    return o;
  endfunction
  task automatic put(input logic rn, input bit chk, input logic [OW-1:0] opc,
                     input logic z, lt, r, res, input out_t e, input string tag);
    vec_t v;
    v.rst_n = rn; v.chk = chk; v.opc = opc; v.z = z; v.lt = lt;
    v.rdy = r; v.res = res; v.exp = e; v.tag = tag;
    vq.push_back(v);
  endtask
  task automatic reset_seq(input bit chk, input out_t e);
    put(1'b0, chk, ro(), rb(), rb(), rb(), rb(), e, "in_reset");
    ill_s = 1'b0;
    be_s  = 1'b0;
    put(1'b1, 1'b1, ro(), rb(), rb(), rb(), rb(), '0, "reset_state");
  endtask
  task automatic access(input int kind, input int w, input string tag, output bit to);
    out_t e = base();
    int   nw;
    e.mr  = kind != 2;
    e.mw  = kind == 2;
    e.m2r = kind == 1;
    to = WAIT_EN && w >= TMO;
    nw = !WAIT_EN ? 0 : to ? TMO : w;
    for (int i = 0; i < nw; i++) put(1'b1, 1'b1, ro(), rb(), rb(), 1'b0, rb(), e, {tag, "_wait"});
    if (to) be_s = 1'b1;
    else begin
      e.ir  = kind == 0;
      e.pcw = kind == 2;
      e.ret = kind == 2;
      put(1'b1, 1'b1, ro(), rb(), rb(), WAIT_EN ? 1'b1 : (w == 0), rb(), e, {tag, "_done"});
    end
  endtask
  task automatic halt_phase(input int h);
    out_t e = base();
    e.hlt = 1'b1;
    for (int i = 0; i < h; i++) put(1'b1, 1'b1, ro(), rb(), rb(), rb(), 1'b0, e, "halt");
    put(1'b1, 1'b1, ro(), rb(), rb(), rb(), 1'b1, e, "halt_resume");
  endtask
  task automatic instr(input logic [OW-1:0] opc, input logic z, lt, input int wf, wm, h);
    bit   to, t;
    out_t e;
    int   op = int'(opc[3:0]);
    bit   ill = (opc >> 4) != 0;
    access(0, wf, "fetch", to);
    if (to) begin halt_phase(h); return; end
    e = base();
    if (!ill) e.alu = AW'(alu_tab[op]);
    put(1'b1, 1'b1, opc, z, lt, rb(), rb(), e, "exec");
    if (ill) ill_s = 1'b1;
    if (ill || op == 15) begin halt_phase(h); return; end
    if (op == 9) begin
      access(1, wm, "memrd", to);
      if (to) begin halt_phase(h); return; end
    end
    if (op == 10) begin
      access(2, wm, "memwr", to);
      if (to) halt_phase(h);
      return;
    end
    e = base();
    e.pcw = 1'b1;
    e.ret = 1'b1;
    if (op >= 11) begin
      t = op == 11 ? z : op == 12 ? !z : lt;
      e.pcs = op == 14 ? 2'd2 : {1'b0, t};
    end else begin
      e.rw  = 1'b1;
      e.m2r = op == 9;
    end
    put(1'b1, 1'b1, ro(), rb(), rb(), rb(), rb(), e, op >= 11 ? "branch" : "writeback");
  endtask
  initial begin
    bit   to;
    out_t e;
    logic [OW-1:0] opc;
    reset_seq(1'b0, '0);
    instr(6'd0, 1'b0, 1'b0, 0, 0, 0);
    instr(6'd9, 1'b0, 1'b0, 0, 2, 0);
    instr(6'd11, 1'b1, 1'b0, 0, 0, 0);
    instr(6'd12, 1'b1, 1'b0, 0, 0, 0);
    instr(6'd14, 1'b0, 1'b0, 0, 0, 0);
    instr(6'd13, 1'b0, 1'b1, 1, 0, 0);
    instr(6'd11, 1'b0, 1'b1, 0, 0, 0);
    instr(6'b010000, 1'b0, 1'b0, 0, 0, 2);
    instr(6'd4, 1'b0, 1'b0, 0, 0, 0);
    instr(6'd10, 1'b0, 1'b0, 0, 5, 1);
    instr(6'd2, 1'b0, 1'b0, TMO - 1, 0, 0);
    instr(6'd15, 1'b0, 1'b0, 0, 0, 3);
    instr(6'd9, 1'b0, 1'b0, TMO, 0, 0);
    access(0, 0, "fetch", to);
    put(1'b1, 1'b1, 6'd9, rb(), rb(), rb(), rb(), base(), "exec_lw");
    e = base();
    e.mr  = 1'b1;
    e.m2r = 1'b1;
    reset_seq(1'b1, e);
    for (int n = 0; n < 120; n++) begin
      opc = $urandom_range(0, 7) == 0 ? OW'({2'($urandom_range(1, 3)), 4'($urandom)}) : OW'(4'($urandom));
      instr(opc, rb(), rb(), $urandom_range(0, 2) == 0 ? $urandom_range(0, 4) : 0,
            $urandom_range(0, 2) == 0 ? $urandom_range(0, 4) : 0, $urandom_range(0, 3));
    end
    for (int i = 0; i < vq.size(); i++) begin
      out_t g;
      @(negedge clk);
      rst_n = vq[i].rst_n; Opcode = vq[i].opc; alu_zero = vq[i].z;
      alu_lt = vq[i].lt; mem_ready = vq[i].rdy; resume = vq[i].res;
      #1;
      g = {ALUOp, MemRead, MemWrite, RegWrite, PCWrite, IRWrite, MemToReg, PCSrc,
           halted, illegal_op, bus_error, retire};
      if (vq[i].chk) begin
        total++;
        if (g !== vq[i].exp) begin
          bad++;
          $display("FAIL %s vec %0d: got %h expected %h", vq[i].tag, i, g, vq[i].exp);
        end
      end
      if (vq[i].tag == "reset_state") begin
        total++;
        if (g !== out_t'('0)) begin
          bad++;
          $display("FAIL reset_state vec %0d: outputs %h not all zero", i, g);
        end
      end
      if (vq[i].chk && vq[i].exp.be && vq[i].exp.hlt) begin
        total++;
        if (halted !== 1'b1 || bus_error !== 1'b1) begin
          bad++;
          $display("FAIL expired_wait vec %0d: halted=%b bus_error=%b", i, halted, bus_error);
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the 8-bit CPU: sequences FETCH/EXECUTE/memory/writeback/branch states per instruction, drives datapath enables and ALU operation select, and resolves branches from ALU flags. Adds memory wait-state handshaking with a timeout, explicit branch/jump PC source selection, illegal-opcode trapping and a resumable HALT. Sits between the instruction register decoder and the datapath (PC, register file, RAM, ALU).

## Interface
- OPCODE_W, 4: opcode width; must be ≥4; any set bit above [3:0] makes the opcode illegal.
- ALUOP_W, 4: ALU op width; must be ≥4; codes zero-extended.
- MEM_TIMEOUT, 15: max wait cycles for `mem_ready` per access; must be ≥1.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- Opcode  in  OPCODE_W  from decoder, sampled in EXECUTE.
- alu_zero  in  1  ALU result == 0 (A == B for EQ op).
- alu_lt  in  1  ALU less-than flag.
- mem_ready  in  1  RAM access complete this cycle.
- resume  in  1  leave HALT.
- ALUOp  out  ALUOP_W  ALU operation.
- MemRead, MemWrite, RegWrite, PCWrite, IRWrite  out  1 each  datapath enables.
- MemToReg  out  1  writeback source: 1 = RAM data, 0 = ALU.
- PCSrc  out  2  0 = PC+1, 1 = branch target, 2 = jump target.
- halted  out  1  in HALT.
- illegal_op  out  1  sticky, set on illegal opcode.
- bus_error  out  1  sticky, set on memory timeout.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- States: RESET, FETCH, EXECUTE, MEM_RD, MEM_WR, WRITEBACK, BRANCH, HALT. Outputs are a function of state (and Opcode in EXECUTE); unlisted outputs are 0.
- RESET: all outputs 0; next FETCH.
- FETCH: MemRead=1; IRWrite=1 only in the cycle `mem_ready`=1, then EXECUTE; else stay.
- EXECUTE by Opcode[3:0]: addi/add → ALUOp 0, WRITEBACK; subi/sub → 1, WRITEBACK; slt/slti → 14, WRITEBACK; sra → 5, sll → 4, nand → 12, all to WRITEBACK; lw → ALUOp 0, MEM_RD; sw → ALUOp 0, MEM_WR; beq/bne → 15, BRANCH; blt → 14, BRANCH; jump → BRANCH; HLT → HALT.
- Illegal opcode: set illegal_op, go HALT, no writes.
- MEM_RD: MemRead=1; on `mem_ready` → WRITEBACK with MemToReg held 1 through WRITEBACK.
- MEM_WR: MemWrite=1; on `mem_ready`: PCWrite=1, PCSrc=0, retire=1, → FETCH.
- WRITEBACK: RegWrite=1, PCWrite=1, PCSrc=0, retire=1, → FETCH.
- BRANCH: PCWrite=1, retire=1; PCSrc = 2 for jump; 1 if taken (beq: alu_zero; bne: !alu_zero; blt: alu_lt), else 0; flags latched at end of EXECUTE.
- HALT: halted=1, PC not advanced; resume=1 → FETCH (resume does not clear sticky flags; only reset does).
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle without `mem_ready`; reaching MEM_TIMEOUT sets bus_error and enters HALT without completing the access.

## Timing
- Zero-wait memory: ALU ops 3 cycles, lw 4, sw 3, branch/jump 3, HLT 2 to halted.
- Each wait cycle extends the owning state by one.
- rst_n low at any edge: state → RESET, counter, illegal_op and bus_error cleared; outputs 0 next cycle regardless of state. First FETCH the cycle after rst_n returns high.
- `mem_ready` sampled only in FETCH/MEM_RD/MEM_WR; ignored elsewhere.
- mem_ready on the same edge the counter reaches MEM_TIMEOUT: completion wins, no bus_error.
- resume ignored outside HALT.

## Configuration
- MULTICYCLE_CTRL_MEM_WAIT_EN defined: handshake and timeout as above.
- Undefined: `mem_ready` treated as constant 1, wait counter and bus_error logic removed (bus_error tied 0); fixed latencies as zero-wait.

## Test plan
- Reset then add with mem_ready=1 → FETCH, EXECUTE (ALUOp=0), WRITEBACK (RegWrite=1, PCWrite=1, retire=1); FETCH again cycle 4.
- lw with mem_ready low 2 cycles in MEM_RD → MEM_RD lasts 3 cycles, MemToReg=1 in WRITEBACK, total 6 cycles.
- beq alu_zero=1 → PCSrc=1; bne alu_zero=1 → PCSrc=0; jump → PCSrc=2; each PCWrite=1 once.
- OPCODE_W=6, Opcode=6'b010000 → illegal_op=1, halted=1, no RegWrite/MemWrite; resume=1 → FETCH, illegal_op stays 1.
- MEM_TIMEOUT=3, sw with mem_ready stuck 0 → bus_error=1 after 3 MEM_WR cycles, HALT, no PCWrite; macro undefined → completes in 3 cycles.
- rst_n low mid-MEM_RD → next cycle all outputs 0, flags cleared, FETCH after release.
